mem_port_controller: RTL and testbench
======================================

Name: mem_port_controller

Overview:
- Sits directly downstream of the CPU core's memory outputs (Aaddr, Baddr, dataWrite, rw) and upstream of its memory inputs (AmemRead, BmemRead).
- Time-multiplexes one asynchronous 16-bit SRAM between two ports: data port A (read/write) and instruction port B (fetch only).
- Uses a multi-cycle strobe FSM and a req/busy/done handshake so the core can stall while the SRAM is in use.

Parameters:
- ACCESS_CYCLES, 2: number of cycles each SRAM strobe (read or write) is held low; legal range 1..15.
- ADDR_W, 18: SRAM address width; the 16-bit port address is zero-extended to this width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  one-cycle request pulse; captures Aaddr, Baddr, dataWrite, rw.
- Aaddr  input  16  data port address.
- Baddr  input  16  instruction fetch address.
- dataWrite  input  16  data written on an A write.
- rw  input  2  A operation: 00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- AmemRead  output  16  registered A read data; held until the next done.
- BmemRead  output  16  registered fetched instruction; held until the next done.
- busy  output  1  high from the cycle after request capture through the DONE cycle inclusive.
- done  output  1  one-cycle pulse; AmemRead and BmemRead are valid from this cycle.
- sram_addr  output  ADDR_W  SRAM address.
- sram_data_out  output  16  write data to the external tristate.
- sram_data_in  input  16  read data from the SRAM.
- sram_data_oe  output  1  high means drive sram_data_out onto the bus.
- sram_ce_n  output  1  chip enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_we_n  output  1  write enable, active low.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0; AmemRead=0, BmemRead=0; sram_addr=0, sram_data_out=0, sram_data_oe=0; sram_ce_n=sram_oe_n=sram_we_n=1. Strobes deassert immediately, even mid-access; an access in flight is abandoned and done is never issued for it.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, B_STROBE, DONE. A cycle counter of 4 bits counts strobe cycles.
- IDLE:
  - All strobes high; sram_data_oe=0.
  - req=1 captures the inputs. Next state is A_STROBE for rw=01, A_SETUP for rw=10, B_STROBE for rw=00 or 11.
  - req=0 stays in IDLE.
  - req while busy=1 is ignored: no capture, no effect.
- A_SETUP (1 cycle, write only): sram_addr=Aaddr, sram_data_out=dataWrite, sram_data_oe=1, ce_n=0, we_n=1, oe_n=1.
- A_STROBE (ACCESS_CYCLES cycles): ce_n=0, sram_addr=Aaddr.
  - Read: oe_n=0; AmemRead is loaded from sram_data_in on the last cycle.
  - Write: we_n=0, oe_n=1, data_oe=1.
  - Exits to A_HOLD for a write, B_STROBE for a read.
- A_HOLD (1 cycle, write only): we_n=1, data_oe=1, data and address unchanged, ce_n=0. Next state is B_STROBE.
- B_STROBE (ACCESS_CYCLES cycles): sram_addr=Baddr, oe_n=0, ce_n=0, data_oe=0; BmemRead is loaded from sram_data_in on the last cycle. Next state is DONE.
- DONE (1 cycle): done=1, strobes high; next state IDLE. A req in DONE is ignored; the next req is accepted in IDLE.
- Invariants:
  - sram_data_oe and sram_oe_n=0 are never simultaneously active.
  - we_n falls only while address and data are already stable (A_SETUP precedes it) and rises one cycle before data_oe drops (A_HOLD).
- AmemRead is unchanged by idle or write requests. BmemRead updates on every completed request.
- Latency from the req sample edge to done high, with N=ACCESS_CYCLES:
  - idle: N+1 cycles.
  - read: 2N+1 cycles.
  - write: 2N+3 cycles.
  - With N=2 these are 3, 5 and 7.
- Address mapping: sram_addr = zero-extended 16-bit address. Address FFFF maps to 0x0FFFF; there is no wrap.
- Same-address write then fetch (Aaddr==Baddr, rw=10): the B fetch returns the newly written dataWrite.

Test Plan:
- Idle fetch: SRAM[0x0010]=0x4801, req with rw=00, Baddr=0x0010 -> no A strobe, done 3 cycles after req, BmemRead=0x4801, AmemRead unchanged (0).
- Read plus fetch: SRAM[0x8000]=0xBEEF, SRAM[0x0011]=0x1234, rw=01 -> oe_n low 4 cycles, we_n stays 1, done at cycle 5, AmemRead=0xBEEF, BmemRead=0x1234.
- Write then fetch of the same address: rw=10, Aaddr=Baddr=0x0020, dataWrite=0xA5A5 -> SETUP, we_n low 2 cycles, HOLD, done at cycle 7, BmemRead=0xA5A5. Checker asserts data_oe and oe_n are never both active.
- Back-to-back and ignored requests: req held high continuously -> exactly one capture per IDLE visit, done pulses spaced by latency+1; rw=11 behaves as 00 with no we_n pulse.
- Reset mid-write: assert rst=0 during A_STROBE -> we_n, ce_n go high and data_oe goes low the same cycle (asynchronously); after release, state IDLE, busy=0, no done.
- Parameter sweep ACCESS_CYCLES=1 and 5: read latency 3 and 11; Aaddr=0xFFFF drives sram_addr=0x0FFFF.

Source files
------------

// File: rtl/mem_port_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  mem_port_controller
//  Time-multiplexes one asynchronous 16-bit SRAM between a read/write data
//  port (A) and an instruction fetch port (B). Each request runs an optional
//  A access followed by a B fetch, then pulses done for one cycle.
//  Revision: 1.0  initial release
// ============================================================================
module mem_port_controller #(
  parameter int ACCESS_CYCLES = 2,   // strobe length in cycles, 1..15
  parameter int ADDR_W        = 18   // SRAM address width, >= 16
) (
  input  logic              clk,
  input  logic              rst,            // asynchronous, active low
  input  logic              req,
  input  logic [15:0]       Aaddr,
  input  logic [15:0]       Baddr,
  input  logic [15:0]       dataWrite,
  input  logic [1:0]        rw,
  output logic [15:0]       AmemRead,
  output logic [15:0]       BmemRead,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_data_out,
  input  logic [15:0]       sram_data_in,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_SETUP  = 3'd1,
    A_STROBE = 3'd2,
    A_HOLD   = 3'd3,
    B_STROBE = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        last;

  // Request fields captured on acceptance
  logic [15:0] a_addr, b_addr, wr_data;
  logic        op_write;
  logic [15:0] a_addr_nxt, b_addr_nxt, wr_data_nxt;
  logic        op_write_nxt;
  logic        capture;

  // Registered SRAM/handshake outputs are decoded from the next state so the
  // strobes come straight out of flops and cannot glitch.
  logic [ADDR_W-1:0] addr_nxt;
  logic [15:0]       dout_nxt;
  logic              doe_nxt, ce_nxt, oe_nxt, we_nxt;

  assign last = (cnt == LAST_CNT);

  // State and strobe-counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; a request is only accepted while IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_nxt = 4'd0;
          case (rw)
            2'b01:   state_nxt = A_STROBE;
            2'b10:   state_nxt = A_SETUP;
            default: state_nxt = B_STROBE;   // 00 idle, 11 reserved
          endcase
        end
      end
      A_SETUP: state_nxt = A_STROBE;
      A_STROBE: begin
        if (last) begin
          cnt_nxt   = 4'd0;
          state_nxt = op_write ? A_HOLD : B_STROBE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      A_HOLD: state_nxt = B_STROBE;
      B_STROBE: begin
        if (last) begin
          cnt_nxt   = 4'd0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Values the request fields will hold next cycle
  always_comb begin
    a_addr_nxt   = capture ? Aaddr            : a_addr;
    b_addr_nxt   = capture ? Baddr            : b_addr;
    wr_data_nxt  = capture ? dataWrite        : wr_data;
    op_write_nxt = capture ? (rw == 2'b10)    : op_write;
  end

  // SRAM pin values for the upcoming state; data_oe and oe_n never overlap
  always_comb begin
    addr_nxt = '0;
    dout_nxt = 16'd0;
    doe_nxt  = 1'b0;
    ce_nxt   = 1'b1;
    oe_nxt   = 1'b1;
    we_nxt   = 1'b1;
    case (state_nxt)
      A_SETUP, A_HOLD: begin
        ce_nxt   = 1'b0;
        doe_nxt  = 1'b1;
        addr_nxt = ADDR_W'(a_addr_nxt);
        dout_nxt = wr_data_nxt;
      end
      A_STROBE: begin
        ce_nxt   = 1'b0;
        addr_nxt = ADDR_W'(a_addr_nxt);
        if (op_write_nxt) begin
          we_nxt   = 1'b0;
          doe_nxt  = 1'b1;
          dout_nxt = wr_data_nxt;
        end else begin
          oe_nxt   = 1'b0;
        end
      end
      B_STROBE: begin
        ce_nxt   = 1'b0;
        oe_nxt   = 1'b0;
        addr_nxt = ADDR_W'(b_addr_nxt);
      end
      default: ;
    endcase
  end

  // Request capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_addr   <= 16'd0;
      b_addr   <= 16'd0;
      wr_data  <= 16'd0;
      op_write <= 1'b0;
    end else begin
      a_addr   <= a_addr_nxt;
      b_addr   <= b_addr_nxt;
      wr_data  <= wr_data_nxt;
      op_write <= op_write_nxt;
    end
  end

  // Output flops; reset drops every strobe at once, even mid-access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr     <= '0;
      sram_data_out <= 16'd0;
      sram_data_oe  <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      sram_addr     <= addr_nxt;
      sram_data_out <= dout_nxt;
      sram_data_oe  <= doe_nxt;
      sram_ce_n     <= ce_nxt;
      sram_oe_n     <= oe_nxt;
      sram_we_n     <= we_nxt;
      busy          <= (state_nxt != IDLE);
      done          <= (state_nxt == DONE);
    end
  end

  // Read data capture at the end of the final strobe cycle of each read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AmemRead <= 16'd0;
      BmemRead <= 16'd0;
    end else begin
      if (state == A_STROBE && !op_write && last) AmemRead <= sram_data_in;
      if (state == B_STROBE && last)              BmemRead <= sram_data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_mem_port_controller
//  Three controllers (ACCESS_CYCLES = 2, 1, 5) share one stimulus stream.
//  Each has its own SRAM model and a transaction-timeline reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_mem_port_controller;

  localparam int NINST = 3;
  localparam int HALF  = 5;

  logic clk = 1'b0;
  always #HALF clk = ~clk;

  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [15:0] Aaddr = 16'd0, Baddr = 16'd0, dataWrite = 16'd0;
  logic [1:0]  rw = 2'b00;

  logic [15:0] amem_v [NINST];
  logic [15:0] bmem_v [NINST];
  logic [15:0] dout_v [NINST];
  logic [17:0] addr_v [NINST];
  logic        busy_v [NINST];
  logic        done_v [NINST];
  logic        doe_v  [NINST];
  logic        ce_v   [NINST];
  logic        oe_v   [NINST];
  logic        we_v   [NINST];

  int tests = 0;
  int fails = 0;

  // Per-transaction observations collected by the directed task
  int          first_done [NINST];
  int          oe_low     [NINST];
  int          we_low     [NINST];
  logic [17:0] addr_c1    [NINST];

  // Initial SRAM contents, shared by the SRAM models and the reference
  function automatic logic [15:0] init_val(input logic [17:0] a);
    logic [31:0] t;
    case (a)
      18'h00010: return 16'h4801;
      18'h00011: return 16'h1234;
      18'h08000: return 16'hBEEF;
      default: begin
        t = 32'(a) * 32'd40503;
        return t[15:0] ^ 16'h1357;
      end
    endcase
  endfunction

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s inst%0d: got %0h expected %0h at %0t",
                 name, inst, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NINST; gi++) begin : g_cfg
    localparam int N = (gi == 0) ? 2 : (gi == 1) ? 1 : 5;

    logic [15:0] din = 16'hDEAD;
    logic [15:0] sram_m [int];
    logic [15:0] ref_m  [int];

    // Reference model: one transaction timeline, cycle k = 1..len after accept
    logic        m_active = 1'b0;
    int          m_k   = 0;
    int          m_len = 0;
    logic [1:0]  m_op  = 2'b00;
    logic [15:0] m_a = 16'd0, m_b = 16'd0, m_d = 16'd0;
    logic [15:0] exp_a = 16'd0, exp_b = 16'd0;

    mem_port_controller #(.ACCESS_CYCLES(N), .ADDR_W(18)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .Aaddr        (Aaddr),
      .Baddr        (Baddr),
      .dataWrite    (dataWrite),
      .rw           (rw),
      .AmemRead     (amem_v[gi]),
      .BmemRead     (bmem_v[gi]),
      .busy         (busy_v[gi]),
      .done         (done_v[gi]),
      .sram_addr    (addr_v[gi]),
      .sram_data_out(dout_v[gi]),
      .sram_data_in (din),
      .sram_data_oe (doe_v[gi]),
      .sram_ce_n    (ce_v[gi]),
      .sram_oe_n    (oe_v[gi]),
      .sram_we_n    (we_v[gi])
    );

    // SRAM model: write stored at the end of every cycle with ce_n/we_n low
    always @(posedge clk) begin
      if (!ce_v[gi] && !we_v[gi]) sram_m[int'(addr_v[gi])] = dout_v[gi];
    end

    // SRAM model: read data presented mid-cycle while ce_n/oe_n are low
    always @(negedge clk) begin
      if (!ce_v[gi] && !oe_v[gi])
        din = sram_m.exists(int'(addr_v[gi])) ? sram_m[int'(addr_v[gi])]
                                                : init_val(addr_v[gi]);
      else
        din = 16'hDEAD;
    end

    // Reference model update
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_active = 1'b0;
        m_k      = 0;
        exp_a    = 16'd0;
        exp_b    = 16'd0;
      end else if (m_active) begin
        if (m_k == m_len) begin
          m_active = 1'b0;
        end else begin
          m_k++;
          if (m_op == 2'b01 && m_k == N + 1)
            exp_a = ref_m.exists(int'(m_a)) ? ref_m[int'(m_a)] : init_val({2'b00, m_a});
          if (m_op == 2'b10 && m_k == N + 2)
            ref_m[int'(m_a)] = m_d;
          if (m_k == m_len)
            exp_b = ref_m.exists(int'(m_b)) ? ref_m[int'(m_b)] : init_val({2'b00, m_b});
        end
      end else if (req) begin
        m_active = 1'b1;
        m_k      = 1;
        m_op     = rw;
        m_a      = Aaddr;
        m_b      = Baddr;
        m_d      = dataWrite;
        m_len    = (rw == 2'b10) ? 2 * N + 3 : (rw == 2'b01) ? 2 * N + 1 : N + 1;
      end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
      logic        eb, ed, ece, eoe, ewe, edoe;
      logic [17:0] eaddr;
      logic [15:0] edout;
      int          s;
      eb = 1'b0; ed = 1'b0; ece = 1'b1; eoe = 1'b1; ewe = 1'b1; edoe = 1'b0;
      eaddr = 18'd0; edout = 16'd0;
      s = (m_op == 2'b10) ? N + 2 : (m_op == 2'b01) ? N : 0;
      if (rst && m_active) begin
        eb = 1'b1;
        if (m_op == 2'b10 && m_k <= N + 2) begin
          ece = 1'b0; edoe = 1'b1; eaddr = {2'b00, m_a}; edout = m_d;
          ewe = !(m_k >= 2 && m_k <= N + 1);
        end else if (m_op == 2'b01 && m_k <= N) begin
          ece = 1'b0; eoe = 1'b0; eaddr = {2'b00, m_a};
        end else if (m_k <= s + N) begin
          ece = 1'b0; eoe = 1'b0; eaddr = {2'b00, m_b};
        end else begin
          ed = 1'b1;
        end
      end
      chk("busy",  gi, 32'(busy_v[gi]), 32'(eb));
      chk("done",  gi, 32'(done_v[gi]), 32'(ed));
      chk("ce_n",  gi, 32'(ce_v[gi]),   32'(ece));
      chk("oe_n",  gi, 32'(oe_v[gi]),   32'(eoe));
      chk("we_n",  gi, 32'(we_v[gi]),   32'(ewe));
      chk("data_oe", gi, 32'(doe_v[gi]), 32'(edoe));
      if (!ece || !rst) chk("sram_addr", gi, 32'(addr_v[gi]), 32'(eaddr));
      if (edoe || !rst) chk("sram_data_out", gi, 32'(dout_v[gi]), 32'(edout));
      chk("AmemRead", gi, 32'(amem_v[gi]), 32'(exp_a));
      chk("BmemRead", gi, 32'(bmem_v[gi]), 32'(exp_b));
      chk("oe_doe_overlap", gi, 32'(doe_v[gi] && !oe_v[gi]), 32'd0);
    end
  end

  // Issue one request at the current negedge and watch 30 cycles
  task automatic transact(input logic [1:0] r, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] d);
    for (int i = 0; i < NINST; i++) begin
      first_done[i] = 0; oe_low[i] = 0; we_low[i] = 0; addr_c1[i] = 18'd0;
    end
    rw = r; Aaddr = a; Baddr = b; dataWrite = d; req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < NINST; i++) begin
        if (c == 1) addr_c1[i] = addr_v[i];
        if (!oe_v[i]) oe_low[i]++;
        if (!we_v[i]) we_low[i]++;
        if (done_v[i] && first_done[i] == 0) first_done[i] = c;
      end
    end
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 16'hFFFF;
    return 16'h0100 + 16'($urandom_range(0, 15));
  endfunction

  initial begin
    int e_lat [NINST];
    int e_cnt [NINST];
    int dcount [NINST];

    repeat (3) @(negedge clk);
    for (int i = 0; i < NINST; i++) begin
      chk("reset_busy", i, 32'(busy_v[i]), 32'd0);
      chk("reset_ce_n", i, 32'(ce_v[i]),   32'd1);
      chk("reset_amem", i, 32'(amem_v[i]), 32'd0);
    end
    #2 rst = 1'b1;
    @(negedge clk);

    // Idle fetch
    transact(2'b00, 16'h1234, 16'h0010, 16'h0000);
    e_lat = '{3, 2, 6}; e_cnt = '{2, 1, 5};
    for (int i = 0; i < NINST; i++) begin
      chk("idle_latency", i, 32'(first_done[i]), 32'(e_lat[i]));
      chk("idle_bmem",    i, 32'(bmem_v[i]),     32'h4801);
      chk("idle_amem",    i, 32'(amem_v[i]),     32'h0000);
      chk("idle_oe_low",  i, 32'(oe_low[i]),     32'(e_cnt[i]));
      chk("idle_we_low",  i, 32'(we_low[i]),     32'd0);
    end

    // Read plus fetch
    transact(2'b01, 16'h8000, 16'h0011, 16'h0000);
    e_lat = '{5, 3, 11}; e_cnt = '{4, 2, 10};
    for (int i = 0; i < NINST; i++) begin
      chk("read_latency", i, 32'(first_done[i]), 32'(e_lat[i]));
      chk("read_amem",    i, 32'(amem_v[i]),     32'hBEEF);
      chk("read_bmem",    i, 32'(bmem_v[i]),     32'h1234);
      chk("read_oe_low",  i, 32'(oe_low[i]),     32'(e_cnt[i]));
      chk("read_we_low",  i, 32'(we_low[i]),     32'd0);
    end

    // Write then fetch of the same address
    transact(2'b10, 16'h0020, 16'h0020, 16'hA5A5);
    e_lat = '{7, 5, 13}; e_cnt = '{2, 1, 5};
    for (int i = 0; i < NINST; i++) begin
      chk("write_latency", i, 32'(first_done[i]), 32'(e_lat[i]));
      chk("write_bmem",    i, 32'(bmem_v[i]),     32'hA5A5);
      chk("write_amem",    i, 32'(amem_v[i]),     32'hBEEF);
      chk("write_we_low",  i, 32'(we_low[i]),     32'(e_cnt[i]));
    end

    // Reserved op behaves as idle
    transact(2'b11, 16'h0020, 16'h0010, 16'h1111);
    e_lat = '{3, 2, 6};
    for (int i = 0; i < NINST; i++) begin
      chk("rsvd_latency", i, 32'(first_done[i]), 32'(e_lat[i]));
      chk("rsvd_we_low",  i, 32'(we_low[i]),     32'd0);
      chk("rsvd_bmem",    i, 32'(bmem_v[i]),     32'h4801);
    end

    // Top of the address range: no wrap
    transact(2'b01, 16'hFFFF, 16'h0011, 16'h0000);
    e_lat = '{5, 3, 11};
    for (int i = 0; i < NINST; i++) begin
      chk("ffff_addr",    i, 32'(addr_c1[i]),    32'h0FFFF);
      chk("ffff_latency", i, 32'(first_done[i]), 32'(e_lat[i]));
    end

    // Reset in the first write strobe cycle
    rw = 2'b10; Aaddr = 16'h0030; Baddr = 16'h0031; dataWrite = 16'h5AA5; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NINST; i++) chk("pre_reset_we_n", i, 32'(we_v[i]), 32'd0);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < NINST; i++) begin
      chk("async_we_n", i, 32'(we_v[i]),   32'd1);
      chk("async_ce_n", i, 32'(ce_v[i]),   32'd1);
      chk("async_doe",  i, 32'(doe_v[i]),  32'd0);
      chk("async_busy", i, 32'(busy_v[i]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < NINST; i++) dcount[i] = 0;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < NINST; i++) if (done_v[i]) dcount[i]++;
    end
    for (int i = 0; i < NINST; i++) begin
      chk("no_done_after_reset", i, 32'(dcount[i]), 32'd0);
      chk("busy_after_reset",    i, 32'(busy_v[i]), 32'd0);
    end

    // Random traffic; the last stretch holds req high continuously
    for (int c = 0; c < 700; c++) begin
      req       = (c >= 500) || ($urandom_range(0, 2) == 0);
      rw        = 2'($urandom_range(0, 3));
      Aaddr     = pick_addr();
      Baddr     = ($urandom_range(0, 3) == 0) ? Aaddr : pick_addr();
      dataWrite = 16'($urandom);
      @(negedge clk);
    end
    req = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
